// File: rtl/mux_rr_arbiter.sv
// Purpose: round-robin grant sequencer driving the sel input of an 8:1 selector.
// Latency: 1 cycle from req to gnt/sel/valid; all outputs registered.
// Backpressure: a holder keeps the path until it drops req or hits MAX_BURST.
module mux_rr_arbiter #(
  parameter int N         = 8,
  parameter int MAX_BURST = 4,
  localparam int SW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [SW-1:0] sel,
  output logic [N-1:0]  gnt,
  output logic          valid,
  output logic [3:0]    burst_cnt
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [3:0]    burst_q, burst_d;

  logic [SW-1:0] arb_ptr;
  logic [SW-1:0] win_idx;
  logic          win_found;
  logic          rel;

  // First asserted request at ptr, ptr+1, ... modulo N. Scanning offsets from
  // high to low lets the smallest offset overwrite the result last.
  function automatic logic [SW:0] pick(input logic [N-1:0] r, input logic [SW-1:0] p);
    logic [SW:0]   res;
    logic [SW-1:0] idx;
    int            k;
    res = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k   = (int'(p) + i) % N;
      idx = SW'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Single arbitration point shared by the idle-grant and release paths.
  always_comb begin
    {win_found, win_idx} = pick(req, arb_ptr);
  end

  // Next-state: hold or extend the tenure, otherwise rearbitrate from the pointer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    burst_d = burst_q;
    arb_ptr = ptr_q;
    rel     = 1'b0;

    case (state_q)
      IDLE: rel = 1'b1;
      GRANT: begin
        if (!req[sel_q] || (burst_q == 4'(MAX_BURST))) begin
          rel     = 1'b1;
          arb_ptr = (sel_q == SW'(N - 1)) ? '0 : sel_q + 1'b1;
          ptr_d   = arb_ptr;
        end else begin
          burst_d = burst_q + 4'd1;
        end
      end
      default: rel = 1'b1;
    endcase

    if (rel) begin
      if (win_found) begin
        state_d = GRANT;
        sel_d   = win_idx;
        gnt_d   = {{(N-1){1'b0}}, 1'b1} << win_idx;
        burst_d = 4'd1;
      end else begin
        // sel deliberately holds its last value while idle
        state_d = IDLE;
        gnt_d   = '0;
        burst_d = 4'd0;
      end
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      burst_q <= 4'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      burst_q <= burst_d;
    end
  end

  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign valid     = (state_q == GRANT);
  assign burst_cnt = burst_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: hand-computed grant sequences plus
// per-cycle invariant checks on the registered outputs.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       valid;
  logic [3:0] burst_cnt;

  int n_checks = 0;
  int n_errs   = 0;

  mux_rr_arbiter #(.N(8), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .sel       (sel),
    .gnt       (gnt),
    .valid     (valid),
    .burst_cnt (burst_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] e_gnt, input logic [2:0] e_sel,
                         input logic e_vld, input logic [3:0] e_bc);
    chk({tag, "_gnt"},   32'(gnt),       32'(e_gnt));
    chk({tag, "_sel"},   32'(sel),       32'(e_sel));
    chk({tag, "_valid"}, 32'(valid),     32'(e_vld));
    chk({tag, "_burst"}, 32'(burst_cnt), 32'(e_bc));
  endtask

  // Structural invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("inv_onehot", 32'($onehot0(gnt)), 32'd1);
      chk("inv_valid",  32'(valid), 32'(|gnt));
      if (valid) chk("inv_gnt_sel", 32'(gnt[sel]), 32'd1);
      chk("inv_burst_max", 32'(burst_cnt <= 4'd4), 32'd1);
    end
  end

  initial begin
    rst = 1'b0;
    req = 8'h00;

    // 1. Asynchronous reset before any clock edge.
    #1;
    rst = 1'b1;
    req = 8'hFF;
    #1;
    chk_out("rst_async", 8'h00, 3'd0, 1'b0, 4'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_out("rst_first", 8'h01, 3'd0, 1'b1, 4'd1);

    // 3. Full contention: 0..7 then 0, four cycles each, no gaps.
    for (int t = 0; t < 9; t++) begin
      for (int b = 1; b <= 4; b++) begin
        if (!(t == 0 && b == 1)) tick();
        chk($sformatf("rr_t%0d_b%0d_gnt", t, b), 32'(gnt), 32'(8'h01 << (t % 8)));
        chk($sformatf("rr_t%0d_b%0d_sel", t, b), 32'(sel), 32'(t % 8));
        chk($sformatf("rr_t%0d_b%0d_bc", t, b), 32'(burst_cnt), 32'(b));
      end
    end
    tick();
    chk_out("rr_next1", 8'h02, 3'd1, 1'b1, 4'd1);

    // 4. Wrap-around: 6 releases while 7 and 0 request; 7 goes first.
    req = 8'h40;
    tick();
    chk_out("wrap_g6", 8'h40, 3'd6, 1'b1, 4'd1);
    req = 8'h81;
    tick();
    chk_out("wrap_g7", 8'h80, 3'd7, 1'b1, 4'd1);
    tick();
    tick();
    tick();
    chk_out("wrap_g7_b4", 8'h80, 3'd7, 1'b1, 4'd4);
    tick();
    chk_out("wrap_g0", 8'h01, 3'd0, 1'b1, 4'd1);

    // 2. Single short request from idle.
    req = 8'h00;
    tick();
    chk_out("idle0", 8'h00, 3'd0, 1'b0, 4'd0);
    req = 8'h04;
    tick();
    chk_out("short_c1", 8'h04, 3'd2, 1'b1, 4'd1);
    tick();
    chk_out("short_c2", 8'h04, 3'd2, 1'b1, 4'd2);
    req = 8'h00;
    tick();
    chk_out("short_rel", 8'h00, 3'd2, 1'b0, 4'd0);
    tick();
    chk_out("short_idle", 8'h00, 3'd2, 1'b0, 4'd0);

    // 5. Sole requester: burst expiry regrants without a gap.
    req = 8'h20;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("sole_c%0d_gnt", c), 32'(gnt), 32'h20);
      chk($sformatf("sole_c%0d_bc", c), 32'(burst_cnt), 32'((c % 4) + 1));
    end
    req = 8'h00;
    tick();
    chk_out("sole_rel", 8'h00, 3'd5, 1'b0, 4'd0);

    // 6. Reset in the middle of a tenure.
    req = 8'h08;
    tick();
    tick();
    chk_out("mid_b2", 8'h08, 3'd3, 1'b1, 4'd2);
    #2;
    rst = 1'b1;
    #1;
    chk_out("mid_rst", 8'h00, 3'd0, 1'b0, 4'd0);
    req = 8'h18;
    tick();
    rst = 1'b0;
    tick();
    chk_out("mid_after", 8'h08, 3'd3, 1'b1, 4'd1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
